// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the single-cycle MIPS fetch/decode path
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [1:0] HC_NONE = 2'b00;
  localparam logic [1:0] HC_OOR  = 2'b01;
  localparam logic [1:0] HC_SELF = 2'b10;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;

endpackage

// File: rtl/ifetch_ctrl_npc_calc.sv
// rtl/ifetch_ctrl_npc_calc.sv - combinational next-PC select, jump > branch > sequential
module npc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic        jump,
  input  logic [25:0] target26,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] branch_off;

  assign pc_plus4   = pc + 32'd4;
  assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], target26, 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - PC register, run-control FSM, halt detection and retire counter
module ifetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IM_DEPTH = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm16,
  input  logic        jump,
  input  logic [25:0] jump_target26,
  output logic [31:0] pc,
  output logic [31:0] im_raddr,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [31:0] instr_count
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] next_pc;
  logic [31:0] pc_plus4_w;
  logic        self_jump;
  logic        out_of_range;

  npc_calc u_npc (
    .pc           (pc_q),
    .branch_taken (branch_taken),
    .imm16        (branch_imm16),
    .jump         (jump),
    .target26     (jump_target26),
    .next_pc      (next_pc),
    .pc_plus4     (pc_plus4_w)
  );

  // Jump has priority in npc_calc, so next_pc is the jump target whenever jump is set.
  assign self_jump    = jump && (next_pc == pc_q);
  assign out_of_range = {2'b00, next_pc[31:2]} >= IM_DEPTH;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      count_q <= '0;
      cause_q <= HC_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        pc_d = RESET_PC;
        if (start) begin
          state_d = RUN;
          count_d = '0;
          cause_d = HC_NONE;
        end
      end
      RUN: begin
        if (!stall) begin
          count_d = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
          // On halt the PC stays on the halting instruction, never the illegal target.
          if (self_jump) begin
            state_d = HALT;
            cause_d = HC_SELF;
          end else if (out_of_range) begin
            state_d = HALT;
            cause_d = HC_OOR;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      HALT: begin
        if (start) begin
          state_d = RUN;
          pc_d    = RESET_PC;
          count_d = '0;
          cause_d = HC_NONE;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = RESET_PC;
      end
    endcase
  end

  assign pc          = pc_q;
  assign im_raddr    = pc_q;
  assign pc_plus4    = pc_plus4_w;
  assign fetch_valid = (state_q == RUN) && !stall;
  assign halted      = (state_q == HALT);
  assign halt_cause  = cause_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb/tb_ifetch_ctrl.sv - directed vector bench for ifetch_ctrl
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_imm16;
  logic        jump;
  logic [25:0] jump_target26;
  logic [31:0] pc;
  logic [31:0] im_raddr;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [31:0] instr_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ifetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_imm16  (branch_imm16),
    .jump          (jump),
    .jump_target26 (jump_target26),
    .pc            (pc),
    .im_raddr      (im_raddr),
    .pc_plus4      (pc_plus4),
    .fetch_valid   (fetch_valid),
    .halted        (halted),
    .halt_cause    (halt_cause),
    .instr_count   (instr_count)
  );

  typedef struct {
    logic        rst;
    logic        st;
    logic        stl;
    logic        bt;
    logic [15:0] imm;
    logic        jmp;
    logic [25:0] tgt;
    logic [31:0] epc;
    logic        efv;
    logic        eh;
    logic [1:0]  ec;
    logic [31:0] en;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic st, logic stl, logic bt, logic [15:0] imm,
                              logic jmp, logic [25:0] tgt, logic [31:0] epc, logic efv,
                              logic eh, logic [1:0] ec, logic [31:0] en);
    vec_t v;
    v.rst = rst; v.st = st; v.stl = stl; v.bt = bt; v.imm = imm; v.jmp = jmp; v.tgt = tgt;
    v.epc = epc; v.efv = efv; v.eh = eh; v.ec = ec; v.en = en;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic st, input logic stl, input logic bt,
                       input logic [15:0] imm, input logic jmp, input logic [25:0] tgt);
    reset = rst; start = st; stall = stl; branch_taken = bt;
    branch_imm16 = imm; jump = jmp; jump_target26 = tgt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] epc, input logic efv,
                           input logic eh, input logic [1:0] ec, input logic [31:0] en);
    chk({tag, ".pc"}, pc, epc);
    chk({tag, ".im_raddr"}, im_raddr, epc);
    chk({tag, ".pc_plus4"}, pc_plus4, epc + 32'd4);
    chk({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, efv});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, eh});
    chk({tag, ".halt_cause"}, {30'd0, halt_cause}, {30'd0, ec});
    chk({tag, ".instr_count"}, instr_count, en);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
    step();
    step();

    //            rst st stl bt imm      jmp tgt       pc   fv h  c  n
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 26'h00, 0,   0, 0, 0, 0));   // reset state
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 26'h00, 0,   0, 0, 0, 0));   // start
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 26'h00, 0,   1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 26'h00, 4,   1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 26'h00, 8,   1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 26'h00, 12,  1, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 26'h00, 16,  1, 0, 0, 4));
    tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 26'h00, 20,  0, 0, 0, 5));   // stall x3
    tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 26'h00, 20,  0, 0, 0, 5));
    tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 1, 26'h05, 20,  0, 0, 0, 5));   // self-jump while stalled
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 26'h00, 20,  1, 0, 0, 5));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 26'h00, 24,  1, 0, 0, 6));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 26'h00, 28,  1, 0, 0, 7));
    tbl.push_back(mk(0, 0, 0, 1, 16'h0009, 0, 26'h00, 32,  1, 0, 0, 8));   // branch +9 -> 72
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 26'h0A, 72,  1, 0, 0, 9));   // jump -> 40
    tbl.push_back(mk(0, 0, 0, 1, 16'hFFFD, 0, 26'h00, 40,  1, 0, 0, 10));  // branch -3 -> 32
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 26'h11, 32,  1, 0, 0, 11));  // jump -> 68
    tbl.push_back(mk(0, 0, 0, 1, 16'h0100, 1, 26'h0E, 68,  1, 0, 0, 12));  // jump beats branch
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 26'h1F, 56,  1, 0, 0, 13));  // jump out of range
    tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 1, 26'h02, 56,  0, 1, 1, 14));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 26'h00, 56,  0, 1, 1, 14));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 26'h00, 56,  0, 1, 1, 14));  // restart
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 26'h00, 0,   1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 26'h00, 4,   1, 0, 0, 1));   // start in RUN ignored
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 26'h0E, 8,   1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 26'h0E, 56,  1, 0, 0, 3));   // jump-to-self
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 26'h00, 56,  0, 1, 2, 4));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 26'h00, 56,  0, 1, 2, 4));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 26'h00, 0,   1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 26'h1C, 4,   1, 0, 0, 1));   // jump -> 112 (word 28)
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 26'h00, 112, 1, 0, 0, 2));   // -> word 29 legal
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 26'h00, 116, 1, 0, 0, 3));   // -> word 30 illegal
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 26'h00, 116, 0, 1, 1, 4));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 26'h00, 0,   1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 1, 26'h10, 4,   1, 0, 0, 1));   // reset beats jump
    tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 26'h00, 0,   0, 0, 0, 0));   // reset beats start
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 26'h00, 0,   0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 26'h00, 0,   0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 26'h00, 0,   1, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].st, tbl[i].stl, tbl[i].bt, tbl[i].imm, tbl[i].jmp, tbl[i].tgt);
      #1;
      check_all($sformatf("v%0d", i), tbl[i].epc, tbl[i].efv, tbl[i].eh, tbl[i].ec, tbl[i].en);
      step();
    end

    // Backward branch from pc 0 wraps to 0xFFFFFFFC, which is out of range.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 26'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
    #1;
    check_all("wrap", 32'd0, 1'b0, 1'b1, 2'b01, 32'd1);

    // Straight-line run from RESET_PC halts after the last legal word.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
    begin
      int cyc = 0;
      while (!halted && cyc < 60) begin
        step();
        cyc++;
      end
      if (!halted) begin
        total++;
        bad++;
        $display("FAIL run_to_halt: halted=%0b expected 1 within 60 cycles", halted);
      end
    end
    #1;
    check_all("linear", 32'd116, 1'b0, 1'b1, 2'b01, 32'd30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
